// File: rtl/pb_ve_multi.sv
// N-channel push-button debouncer on a shared 1 ms tick: press/release/long pulses plus debounced level.
// Optional macro PB_AUTOREPEAT_EN: after KEY_LONG, a held key re-pulses KEY_PRESS every REPEAT_MS ticks.
module pb_ve_multi #(
    parameter int N_KEYS    = 4,
    parameter int DB_MS     = 10,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST_N,
    input  logic              MS_F,
    input  logic [N_KEYS-1:0] KEYIN,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_LONG,
    output logic [N_KEYS-1:0] KEY_LEVEL
);

    localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int DW       = $clog2(DB_MS + 1);
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DB_V   = DW'(DB_MS);
    localparam logic [HW-1:0] LONG_V = HW'(LONG_MS);
`ifdef PB_AUTOREPEAT_EN
    localparam logic [HW-1:0] REP_V  = HW'(REPEAT_MS);
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    for (genvar g = 0; g < N_KEYS; g++) begin : gCh
        logic          keyMeta_q;
        logic          keySync_q;
        state_e        state_q;
        logic [DW-1:0] dcnt_q;
        logic [HW-1:0] hcnt_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          level_q;
`ifdef PB_AUTOREPEAT_EN
        logic          repeat_q;
`endif

        // Synchronizer resets to "released" so no phantom press appears after reset.
        always_ff @(posedge SYS_CLK) begin
            if (!SYS_RST_N) begin
                keyMeta_q <= 1'b1;
                keySync_q <= 1'b1;
                state_q   <= IDLE;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                level_q   <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
                repeat_q  <= 1'b0;
`endif
            end else begin
                keyMeta_q <= KEYIN[g];
                keySync_q <= keyMeta_q;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    IDLE: begin
                        dcnt_q  <= '0;
                        hcnt_q  <= '0;
                        level_q <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
                        repeat_q <= 1'b0;
`endif
                        if (!keySync_q) state_q <= PRESS_DB;
                    end
                    PRESS_DB: begin
                        if (keySync_q) begin
                            state_q <= IDLE;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DB_V) begin
                            state_q <= HELD;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                            dcnt_q  <= '0;
                            hcnt_q  <= '0;
`ifdef PB_AUTOREPEAT_EN
                            repeat_q <= 1'b0;
`endif
                        end else if (MS_F) begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    HELD: begin
                        dcnt_q <= '0;
                        if (keySync_q) begin
                            state_q <= RELEASE_DB;
`ifdef PB_AUTOREPEAT_EN
                        end else if (!repeat_q) begin
                            // Long-press phase; reaching LONG_MS hands hcnt over to the repeat period.
                            if (MS_F && (hcnt_q < LONG_V)) begin
                                if (hcnt_q + HW'(1) == LONG_V) begin
                                    long_q   <= 1'b1;
                                    hcnt_q   <= '0;
                                    repeat_q <= 1'b1;
                                end else begin
                                    hcnt_q <= hcnt_q + HW'(1);
                                end
                            end
                        end else if (hcnt_q == REP_V) begin
                            press_q <= 1'b1;
                            hcnt_q  <= '0;
                        end else if (MS_F) begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
`else
                        end else if (MS_F && (hcnt_q < LONG_V)) begin
                            hcnt_q <= hcnt_q + HW'(1);
                            if (hcnt_q + HW'(1) == LONG_V) long_q <= 1'b1;
                        end
`endif
                    end
                    RELEASE_DB: begin
                        if (!keySync_q) begin
                            state_q <= HELD;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DB_V) begin
                            state_q   <= IDLE;
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                            dcnt_q    <= '0;
                        end else if (MS_F) begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        dcnt_q  <= '0;
                        hcnt_q  <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign KEY_PRESS[g]   = press_q;
        assign KEY_RELEASE[g] = release_q;
        assign KEY_LONG[g]    = long_q;
        assign KEY_LEVEL[g]   = level_q;
    end

endmodule

// File: tb/tb_pb_ve_multi.sv
// Self-checking bench for pb_ve_multi: vector table, hand-timed corner cases and random stimulus
// checked every cycle against a behavioural model of debounced key behaviour.
module tb_pb_ve_multi;

    localparam int N    = 2;
    localparam int DB   = 3;
    localparam int LONG = 8;
    localparam int REP  = 2;
`ifdef PB_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         SYS_CLK = 1'b0;
    logic         SYS_RST_N;
    logic         MS_F;
    logic [N-1:0] KEYIN;
    logic [N-1:0] KEY_PRESS;
    logic [N-1:0] KEY_RELEASE;
    logic [N-1:0] KEY_LONG;
    logic [N-1:0] KEY_LEVEL;

    pb_ve_multi #(
        .N_KEYS   (N),
        .DB_MS    (DB),
        .LONG_MS  (LONG),
        .REPEAT_MS(REP)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST_N  (SYS_RST_N),
        .MS_F       (MS_F),
        .KEYIN      (KEYIN),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_LONG   (KEY_LONG),
        .KEY_LEVEL  (KEY_LEVEL)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;
    int msPhase = 0;
    bit msOn = 1'b1;
    int segPress [N];
    int segRel   [N];
    int segLong  [N];

    // Behavioural model: pin history, debounced level, debounce ticks, held ticks
    logic       mS1 [N];
    logic       mS2 [N];
    bit         mLvl [N];
    bit         mDbAct [N];
    bit         mRep [N];
    int         mDb [N];
    int         mHold [N];
    logic [N-1:0] mPress, mRel, mLong, mLevel;

    typedef struct {
        logic [N-1:0] keys;
        logic         rstN;
        bit           ms;
        int           cycles;
        int           expPress [N];
        int           expRel   [N];
        int           expLong  [N];
        logic [N-1:0] expLevel;
    } vec_t;

    vec_t vecs [$];

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cycleNo);
        end
    endtask

    task automatic checkRange(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic modelStep(input logic [N-1:0] keys, input logic rstN, input logic ms);
        for (int ch = 0; ch < N; ch++) begin
            logic k;
            bit   pressedNow;
            mPress[ch] = 1'b0;
            mRel[ch]   = 1'b0;
            mLong[ch]  = 1'b0;
            if (!rstN) begin
                mS1[ch] = 1'b1; mS2[ch] = 1'b1;
                mLvl[ch] = 0; mDbAct[ch] = 0; mRep[ch] = 0;
                mDb[ch] = 0; mHold[ch] = 0;
            end else begin
                k = mS2[ch];
                mS2[ch] = mS1[ch];
                mS1[ch] = keys[ch];
                pressedNow = (k == 1'b0);
                if (!mDbAct[ch]) begin
                    if (pressedNow != mLvl[ch]) begin
                        mDbAct[ch] = 1;
                        mDb[ch] = 0;
                    end else if (mLvl[ch]) begin
`ifdef PB_AUTOREPEAT_EN
                        if (!mRep[ch]) begin
                            if (ms && mHold[ch] < LONG) begin
                                mHold[ch]++;
                                if (mHold[ch] == LONG) begin
                                    mLong[ch] = 1'b1;
                                    mHold[ch] = 0;
                                    mRep[ch] = 1;
                                end
                            end
                        end else if (mHold[ch] == REP) begin
                            mPress[ch] = 1'b1;
                            mHold[ch] = 0;
                        end else if (ms) begin
                            mHold[ch]++;
                        end
`else
                        if (ms && mHold[ch] < LONG) begin
                            mHold[ch]++;
                            if (mHold[ch] == LONG) mLong[ch] = 1'b1;
                        end
`endif
                    end else begin
                        mDb[ch] = 0; mHold[ch] = 0; mRep[ch] = 0;
                    end
                end else begin
                    if (pressedNow == mLvl[ch]) begin
                        mDbAct[ch] = 0;
                        mDb[ch] = 0;
                    end else if (mDb[ch] == DB) begin
                        mLvl[ch] = pressedNow;
                        mDbAct[ch] = 0;
                        mDb[ch] = 0;
                        if (mLvl[ch]) begin
                            mPress[ch] = 1'b1;
                            mHold[ch] = 0;
                            mRep[ch] = 0;
                        end else begin
                            mRel[ch] = 1'b1;
                        end
                    end else if (ms) begin
                        mDb[ch]++;
                    end
                end
            end
            mLevel[ch] = mLvl[ch];
        end
    endtask

    task automatic checkOutput();
        checkVal("outputs {press,release,long,level}",
                 int'({KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_LEVEL}),
                 int'({mPress, mRel, mLong, mLevel}));
        for (int ch = 0; ch < N; ch++) begin
            segPress[ch] += int'(KEY_PRESS[ch]);
            segRel[ch]   += int'(KEY_RELEASE[ch]);
            segLong[ch]  += int'(KEY_LONG[ch]);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] keys, input logic rstN);
        logic msBit;
        KEYIN     = keys;
        SYS_RST_N = rstN;
        msBit     = msOn && (msPhase == 3);
        MS_F      = msBit;
        @(posedge SYS_CLK);
        modelStep(keys, rstN, msBit);
        msPhase = (msPhase + 1) % 4;
        cycleNo++;
        @(negedge SYS_CLK);
        checkOutput();
    endtask

    task automatic clearSeg();
        for (int ch = 0; ch < N; ch++) begin
            segPress[ch] = 0; segRel[ch] = 0; segLong[ch] = 0;
        end
    endtask

    task automatic addVec(input logic [N-1:0] keys, input logic rstN, input bit ms, input int cycles,
                          input int p0, input int p1, input int r0, input int r1,
                          input int l0, input int l1, input logic [N-1:0] lvl);
        vec_t v;
        v.keys = keys; v.rstN = rstN; v.ms = ms; v.cycles = cycles;
        v.expPress[0] = p0; v.expPress[1] = p1;
        v.expRel[0]   = r0; v.expRel[1]   = r1;
        v.expLong[0]  = l0; v.expLong[1]  = l1;
        v.expLevel = lvl;
        vecs.push_back(v);
    endtask

    initial begin
        int firstPress, longCyc, rep1, rep2, lat, n;
        bit seen;

        SYS_RST_N = 1'b0;
        KEYIN     = 2'b00;
        MS_F      = 1'b0;

        // keys, rstN, ms, cycles, press0/1, release0/1, long0/1, level at end (-1 = not counted)
        addVec(2'b00, 1'b0, 1, 10, 0, 0, 0, 0, 0, 0, 2'b00);
        addVec(2'b11, 1'b1, 1, 20, 0, 0, 0, 0, 0, 0, 2'b00);
        addVec(2'b10, 1'b1, 1, 40, 1, 0, 0, 0, 0, 0, 2'b01);
        addVec(2'b11, 1'b1, 1, 30, 0, 0, 1, 0, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            addVec(2'b10, 1'b1, 1, 8, 0, 0, 0, 0, 0, 0, 2'b00);
            addVec(2'b11, 1'b1, 1, 4, 0, 0, 0, 0, 0, 0, 2'b00);
        end
        addVec(2'b11, 1'b1, 1, 10, 0, 0, 0, 0, 0, 0, 2'b00);
        addVec(2'b10, 1'b1, 1, 20, 1, 0, 0, 0, 0, 0, 2'b01);
        addVec(2'b11, 1'b1, 1, 4,  0, 0, 0, 0, 0, 0, 2'b01);
        addVec(2'b10, 1'b1, 1, 12, 0, 0, 0, 0, 0, 0, 2'b01);
        addVec(2'b11, 1'b1, 1, 30, 0, 0, 1, 0, 0, 0, 2'b00);
        addVec(2'b01, 1'b1, 1, 100, 0, AR ? -1 : 1, 0, 0, 0, 1, 2'b10);
        addVec(2'b11, 1'b1, 1, 30, 0, AR ? -1 : 0, 0, 1, 0, 0, 2'b00);
        addVec(2'b10, 1'b1, 0, 40, 0, 0, 0, 0, 0, 0, 2'b00);
        addVec(2'b11, 1'b1, 0, 10, 0, 0, 0, 0, 0, 0, 2'b00);
        addVec(2'b11, 1'b1, 1, 10, 0, 0, 0, 0, 0, 0, 2'b00);

        @(negedge SYS_CLK);
        foreach (vecs[r]) begin
            clearSeg();
            msOn = vecs[r].ms;
            repeat (vecs[r].cycles) applyStimulus(vecs[r].keys, vecs[r].rstN);
            for (int ch = 0; ch < N; ch++) begin
                if (vecs[r].expPress[ch] >= 0)
                    checkVal($sformatf("row%0d press ch%0d", r, ch), segPress[ch], vecs[r].expPress[ch]);
                checkVal($sformatf("row%0d release ch%0d", r, ch), segRel[ch], vecs[r].expRel[ch]);
                checkVal($sformatf("row%0d long ch%0d", r, ch), segLong[ch], vecs[r].expLong[ch]);
            end
            checkVal($sformatf("row%0d level", r), int'(KEY_LEVEL), int'(vecs[r].expLevel));
        end
        msOn = 1'b1;

        // Long-press timing on ch1 relative to the initial press pulse
        firstPress = -1; longCyc = -1; rep1 = -1; rep2 = -1; n = 0;
        for (int i = 0; i < 160; i++) begin
            applyStimulus(2'b01, 1'b1);
            if (KEY_PRESS[1]) begin
                if (firstPress < 0) firstPress = cycleNo;
                else if (longCyc >= 0 && rep1 < 0) rep1 = cycleNo;
                else if (longCyc >= 0 && rep2 < 0) rep2 = cycleNo;
                if (longCyc >= 0) n++;
            end
            if (KEY_LONG[1] && longCyc < 0) longCyc = cycleNo;
        end
        checkVal("long timeout", int'(longCyc >= 0 && firstPress >= 0), 1);
        checkVal("press-to-long cycles", longCyc - firstPress, 31);
`ifdef PB_AUTOREPEAT_EN
        checkVal("long-to-first-repeat cycles", rep1 - longCyc, 9);
        checkVal("repeat period cycles", rep2 - rep1, 8);
`else
        checkVal("presses after long", n, 0);
`endif
        repeat (30) applyStimulus(2'b11, 1'b1);

        // Simultaneous press on both channels
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(2'b00, 1'b1);
            if (KEY_PRESS != 2'b00) begin
                seen = 1;
                checkVal("simultaneous press", int'(KEY_PRESS), 3);
            end
        end
        checkVal("simultaneous press timeout", int'(seen), 1);
        repeat (30) applyStimulus(2'b11, 1'b1);

        // Reset while ch0 is held with five hold ticks accumulated
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(2'b10, 1'b1);
            if (KEY_PRESS[0]) seen = 1;
        end
        checkVal("mid-hold press timeout", int'(seen), 1);
        repeat (19) applyStimulus(2'b10, 1'b1);
        clearSeg();
        applyStimulus(2'b10, 1'b0);
        checkVal("level after mid-hold reset", int'(KEY_LEVEL[0]), 0);
        seen = 0; lat = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(2'b10, 1'b1);
            lat++;
            if (KEY_PRESS[0]) seen = 1;
        end
        checkVal("re-press after reset timeout", int'(seen), 1);
        checkRange("re-press latency after reset", lat, 13, 16);
        checkVal("release after reset", segRel[0], 0);
        repeat (30) applyStimulus(2'b11, 1'b1);

        // Random bursts, bounces, tick dropouts and resets against the model
        for (int b = 0; b < 80; b++) begin
            logic [N-1:0] keys;
            int dur;
            keys = N'($urandom_range(0, 3));
            dur  = $urandom_range(1, 40);
            msOn = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0)
                repeat ($urandom_range(1, 3)) applyStimulus(keys, 1'b0);
            repeat (dur) applyStimulus(keys, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
